// File: rtl/load_store_unit.sv
// Memory-access stage of the RV32I core.
// Runs one load or store at a time through a req/gnt/rvalid handshake with data memory,
// generates byte enables and lane-replicated store data, and extends load data for writeback.
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid_i,
  input  logic        ex_we_i,
  input  logic [1:0]  ex_size_i,
  input  logic        ex_unsigned_i,
  input  logic [31:0] ex_addr_i,
  input  logic [31:0] ex_wdata_i,
  output logic        lsu_ready_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        wb_valid_o,
  output logic [31:0] wb_data_o,
  output logic        misaligned_o
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e      state_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_wdata_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  off_q;
  logic        wb_valid_q;
  logic [31:0] wb_data_q;
  logic        misaligned_q;

  logic        misaligned;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] shifted;
  logic [31:0] load_data;

  // Alignment check on the operation presented by execute.
  always_comb begin
    misaligned = 1'b0;
    unique case (ex_size_i)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = ex_addr_i[0];
      2'b10:   misaligned = (ex_addr_i[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Byte enables and lane-replicated store data for the incoming operation.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = ex_wdata_i;
    unique case (ex_size_i)
      2'b00: begin
        be_d    = 4'b0001 << ex_addr_i[1:0];
        wdata_d = {4{ex_wdata_i[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << {ex_addr_i[1], 1'b0};
        wdata_d = {2{ex_wdata_i[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = ex_wdata_i;
      end
    endcase
  end

  // Select the addressed lane of the returned word and extend it.
  always_comb begin
    shifted   = mem_rdata_i >> {off_q, 3'b000};
    load_data = shifted;
    unique case (size_q)
      2'b00:   load_data = uns_q ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // Transaction FSM with registered memory and writeback outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_be_q     <= 4'h0;
      mem_wdata_q  <= 32'h0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      off_q        <= 2'b00;
      wb_valid_q   <= 1'b0;
      wb_data_q    <= 32'h0;
      misaligned_q <= 1'b0;
    end else begin
      wb_valid_q   <= 1'b0;
      misaligned_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ex_valid_i) begin
            if (misaligned) begin
              misaligned_q <= 1'b1;
            end else begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= ex_we_i;
              mem_addr_q  <= {ex_addr_i[31:2], 2'b00};
              mem_be_q    <= be_d;
              mem_wdata_q <= wdata_d;
              size_q      <= ex_size_i;
              uns_q       <= ex_unsigned_i;
              off_q       <= ex_addr_i[1:0];
              state_q     <= StReq;
            end
          end
        end
        StReq: begin
          if (mem_gnt_i) begin
            mem_req_q <= 1'b0;
            state_q   <= StWait;
          end
        end
        StWait: begin
          if (mem_rvalid_i) begin
            wb_valid_q <= 1'b1;
            // Stores complete with zero data; writeback ignores it.
            wb_data_q  <= mem_we_q ? 32'h0 : load_data;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign lsu_ready_o  = (state_q == StIdle);
  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_be_o     = mem_be_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign wb_valid_o   = wb_valid_q;
  assign wb_data_o    = wb_data_q;
  assign misaligned_o = misaligned_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        ex_valid_i;
  logic        ex_we_i;
  logic [1:0]  ex_size_i;
  logic        ex_unsigned_i;
  logic [31:0] ex_addr_i;
  logic [31:0] ex_wdata_i;
  logic        lsu_ready_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        wb_valid_o;
  logic [31:0] wb_data_o;
  logic        misaligned_o;

  int checks;
  int failures;

  load_store_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid_i   (ex_valid_i),
    .ex_we_i      (ex_we_i),
    .ex_size_i    (ex_size_i),
    .ex_unsigned_i(ex_unsigned_i),
    .ex_addr_i    (ex_addr_i),
    .ex_wdata_i   (ex_wdata_i),
    .lsu_ready_o  (lsu_ready_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_be_o     (mem_be_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .wb_valid_o   (wb_valid_o),
    .wb_data_o    (wb_data_o),
    .misaligned_o (misaligned_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one operation with immediate grant and rvalid one cycle after grant.
  task automatic run_op(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input logic [31:0] exp_addr,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_wb);
    chk({tag, ":ready_idle"}, 32'(lsu_ready_o), 32'd1);
    ex_valid_i    = 1'b1;
    ex_we_i       = we;
    ex_size_i     = size;
    ex_unsigned_i = uns;
    ex_addr_i     = addr;
    ex_wdata_i    = wdata;
    mem_gnt_i     = 1'b1;
    @(posedge clk); #1;
    ex_valid_i = 1'b0;
    chk({tag, ":req"}, 32'(mem_req_o), 32'd1);
    chk({tag, ":we"}, 32'(mem_we_o), 32'(we));
    chk({tag, ":addr"}, mem_addr_o, exp_addr);
    chk({tag, ":be"}, 32'(mem_be_o), 32'(exp_be));
    chk({tag, ":wdata"}, mem_wdata_o, exp_wdata);
    chk({tag, ":ready_busy"}, 32'(lsu_ready_o), 32'd0);
    @(posedge clk); #1;
    mem_gnt_i = 1'b0;
    chk({tag, ":req_drop"}, 32'(mem_req_o), 32'd0);
    chk({tag, ":wb_early"}, 32'(wb_valid_o), 32'd0);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = rdata;
    @(posedge clk); #1;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    chk({tag, ":wb_valid"}, 32'(wb_valid_o), 32'd1);
    chk({tag, ":wb_data"}, wb_data_o, exp_wb);
    chk({tag, ":ready_back"}, 32'(lsu_ready_o), 32'd1);
    @(posedge clk); #1;
    chk({tag, ":wb_pulse"}, 32'(wb_valid_o), 32'd0);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    ex_valid_i    = 1'b0;
    ex_we_i       = 1'b0;
    ex_size_i     = 2'b00;
    ex_unsigned_i = 1'b0;
    ex_addr_i     = 32'h0;
    ex_wdata_i    = 32'h0;
    mem_gnt_i     = 1'b0;
    mem_rvalid_i  = 1'b0;
    mem_rdata_i   = 32'h0;

    #3;
    chk("rst:ready", 32'(lsu_ready_o), 32'd1);
    chk("rst:req", 32'(mem_req_o), 32'd0);
    chk("rst:we", 32'(mem_we_o), 32'd0);
    chk("rst:addr", mem_addr_o, 32'h0);
    chk("rst:be", 32'(mem_be_o), 32'd0);
    chk("rst:wdata", mem_wdata_o, 32'h0);
    chk("rst:wb_valid", 32'(wb_valid_o), 32'd0);
    chk("rst:wb_data", wb_data_o, 32'h0);
    chk("rst:mis", 32'(misaligned_o), 32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("sb", 1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00A5, 32'h0,
           32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 32'h0);
    run_op("lb", 1'b0, 2'b00, 1'b0, 32'h0000_2002, 32'h0, 32'h1280_3456,
           32'h0000_2000, 4'b0100, 32'h0, 32'hFFFF_FF80);
    run_op("lbu", 1'b0, 2'b00, 1'b1, 32'h0000_2002, 32'h0, 32'h1280_3456,
           32'h0000_2000, 4'b0100, 32'h0, 32'h0000_0080);
    run_op("lh", 1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 32'h8001_BEEF,
           32'h0000_2000, 4'b1100, 32'h0, 32'hFFFF_8001);
    run_op("lhu", 1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 32'h8001_BEEF,
           32'h0000_2000, 4'b1100, 32'h0, 32'h0000_8001);
    run_op("sh", 1'b1, 2'b01, 1'b0, 32'h0000_2000, 32'h1234_BEEF, 32'h0,
           32'h0000_2000, 4'b0011, 32'hBEEF_BEEF, 32'h0);
    run_op("lw", 1'b0, 2'b10, 1'b1, 32'h0000_2004, 32'h0, 32'h8765_4321,
           32'h0000_2004, 4'b1111, 32'h0, 32'h8765_4321);

    // Misaligned word load
    ex_valid_i = 1'b1; ex_we_i = 1'b0; ex_size_i = 2'b10; ex_unsigned_i = 1'b0;
    ex_addr_i  = 32'h0000_1002;
    @(posedge clk); #1;
    ex_valid_i = 1'b0;
    chk("mis_lw:pulse", 32'(misaligned_o), 32'd1);
    chk("mis_lw:req", 32'(mem_req_o), 32'd0);
    chk("mis_lw:ready", 32'(lsu_ready_o), 32'd1);
    @(posedge clk); #1;
    chk("mis_lw:pulse_end", 32'(misaligned_o), 32'd0);
    chk("mis_lw:req_after", 32'(mem_req_o), 32'd0);

    // Illegal size is always misaligned
    ex_valid_i = 1'b1; ex_size_i = 2'b11; ex_addr_i = 32'h0000_2000;
    @(posedge clk); #1;
    ex_valid_i = 1'b0;
    chk("mis_sz3:pulse", 32'(misaligned_o), 32'd1);
    chk("mis_sz3:req", 32'(mem_req_o), 32'd0);
    @(posedge clk); #1;
    chk("mis_sz3:pulse_end", 32'(misaligned_o), 32'd0);

    // Store with grant held off; busy-time ex_valid must be ignored
    ex_valid_i = 1'b1; ex_we_i = 1'b1; ex_size_i = 2'b10; ex_unsigned_i = 1'b0;
    ex_addr_i  = 32'h0000_3000; ex_wdata_i = 32'hDEAD_BEEF;
    mem_gnt_i  = 1'b0;
    @(posedge clk); #1;
    ex_addr_i = 32'h0000_5555; ex_wdata_i = 32'h1111_1111; ex_size_i = 2'b00;
    for (int c = 1; c <= 4; c++) begin
      ex_valid_i = c[0];
      chk($sformatf("stall%0d:req", c), 32'(mem_req_o), 32'd1);
      chk($sformatf("stall%0d:addr", c), mem_addr_o, 32'h0000_3000);
      chk($sformatf("stall%0d:be", c), 32'(mem_be_o), 32'hF);
      chk($sformatf("stall%0d:wdata", c), mem_wdata_o, 32'hDEAD_BEEF);
      chk($sformatf("stall%0d:ready", c), 32'(lsu_ready_o), 32'd0);
      if (c == 4) begin
        mem_gnt_i  = 1'b1;
        ex_valid_i = 1'b0;
      end
      @(posedge clk); #1;
    end
    mem_gnt_i = 1'b0;
    chk("stall:req_drop", 32'(mem_req_o), 32'd0);
    chk("stall:ready_wait", 32'(lsu_ready_o), 32'd0);
    mem_rvalid_i = 1'b1;
    @(posedge clk); #1;
    mem_rvalid_i = 1'b0;
    chk("stall:wb_valid", 32'(wb_valid_o), 32'd1);
    chk("stall:wb_data", wb_data_o, 32'h0);
    @(posedge clk); #1;
    chk("stall:wb_pulse", 32'(wb_valid_o), 32'd0);
    chk("stall:no_new_req", 32'(mem_req_o), 32'd0);

    // Reset while waiting for the load response
    ex_valid_i = 1'b1; ex_we_i = 1'b0; ex_size_i = 2'b10; ex_addr_i = 32'h0000_4000;
    mem_gnt_i  = 1'b1;
    @(posedge clk); #1;
    ex_valid_i = 1'b0;
    chk("rstw:req", 32'(mem_req_o), 32'd1);
    @(posedge clk); #1;
    mem_gnt_i = 1'b0;
    chk("rstw:in_wait", 32'(lsu_ready_o), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw:ready", 32'(lsu_ready_o), 32'd1);
    chk("rstw:addr", mem_addr_o, 32'h0);
    chk("rstw:be", 32'(mem_be_o), 32'd0);
    chk("rstw:req", 32'(mem_req_o), 32'd0);
    #2 rst_n = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hCAFE_F00D;
    @(posedge clk); #1;
    mem_rvalid_i = 1'b0;
    chk("rstw:late_rvalid", 32'(wb_valid_o), 32'd0);
    chk("rstw:wb_data", wb_data_o, 32'h0);
    @(posedge clk); #1;
    chk("rstw:still_idle", 32'(wb_valid_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
